// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage core.
//
// Takes the memory stage's registered outputs and commits results to the
// register-file write port through a two-entry buffer. The buffer absorbs
// cycles where the register file is not ready and back-pressures the memory
// stage when full. Also drives the forwarding value for hazard logic, a
// registered retire pulse and an instructions-retired counter.
//
// Handshake: an input is taken on a rising edge when wb_i_ce is high,
// wb_i_stall and wb_i_flush are low and the buffer is not full
// (wb_o_stall low). The head entry leaves on an edge when it does not write,
// or when it writes and wb_i_rf_ready is high.
//
// Ports:
//   wb_clk, wb_rst             clock (rising edge), async active-high reset
//   wb_i_ce/stall/flush        input valid / memory-stage stall / flush
//   wb_i_opcode, wb_i_rd_*     presented instruction and its result
//   wb_i_load_data             load data for LOAD_WORD
//   wb_i_rf_ready              register-file port accepts a write
//   wb_o_rf_we/addr/data       register-file write port (head entry)
//   wb_o_fwd_we/addr/data      youngest buffered writing entry
//   wb_o_stall                 buffer full
//   wb_o_flush                 registered copy of wb_i_flush
//   wb_o_ce, wb_o_retired      retire pulse and retired-instruction count

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD_WORD
`define LOAD_WORD  7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif
`ifndef RTYPE
`define RTYPE      7'b0110011
`endif
`ifndef ITYPE
`define ITYPE      7'b0010011
`endif
`ifndef JAL
`define JAL        7'b1101111
`endif
`ifndef JALR
`define JALR       7'b1100111
`endif
`ifndef LUI
`define LUI        7'b0110111
`endif
`ifndef AUIPC
`define AUIPC      7'b0010111
`endif
`ifndef BRANCH
`define BRANCH     7'b1100011
`endif

module wb_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int CWIDTH = 32
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic                     wb_i_ce,
    input  logic                     wb_i_stall,
    input  logic                     wb_i_flush,
    input  logic [`OPCODE_WIDTH-1:0] wb_i_opcode,
    input  logic [AWIDTH-1:0]        wb_i_rd_addr,
    input  logic [DWIDTH-1:0]        wb_i_rd_data,
    input  logic                     wb_i_rd_we,
    input  logic [DWIDTH-1:0]        wb_i_load_data,
    input  logic                     wb_i_rf_ready,
    output logic                     wb_o_rf_we,
    output logic [AWIDTH-1:0]        wb_o_rf_addr,
    output logic [DWIDTH-1:0]        wb_o_rf_data,
    output logic                     wb_o_fwd_we,
    output logic [AWIDTH-1:0]        wb_o_fwd_addr,
    output logic [DWIDTH-1:0]        wb_o_fwd_data,
    output logic                     wb_o_stall,
    output logic                     wb_o_flush,
    output logic                     wb_o_ce,
    output logic [CWIDTH-1:0]        wb_o_retired
);

    // Buffer storage: one entry per slot, 1-bit pointers, count 0..2.
    logic              we_q   [2];
    logic [AWIDTH-1:0] addr_q [2];
    logic [DWIDTH-1:0] data_q [2];
    logic              head_q, tail_q;
    logic [1:0]        count_q, count_d;

    logic              ce_q, flush_q;
    logic [CWIDTH-1:0] retired_q;

    logic              new_we;
    logic [DWIDTH-1:0] new_data;
    logic              push, pop;
    logic              empty, full;
    logic              young_idx;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

    // Entry content selected by opcode; x0 is never written.
    always_comb begin
        new_we   = 1'b0;
        new_data = '0;
        case (wb_i_opcode)
            `LOAD_WORD: begin
                new_we   = 1'b1;
                new_data = wb_i_load_data;
            end
            `RTYPE, `ITYPE, `JAL, `JALR, `LUI, `AUIPC: begin
                new_we   = wb_i_rd_we;
                new_data = wb_i_rd_data;
            end
            default: begin
                new_we   = 1'b0;
                new_data = '0;
            end
        endcase
        if (wb_i_rd_addr == '0) begin
            new_we = 1'b0;
        end
    end

    assign push = wb_i_ce && !wb_i_stall && !wb_i_flush && !full;
    // Non-writing entries drain without waiting on the register file.
    assign pop  = !empty && (!we_q[head_q] || wb_i_rf_ready);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            for (int i = 0; i < 2; i++) begin
                we_q[i]   <= 1'b0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            ce_q      <= 1'b0;
            flush_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            if (push) begin
                we_q[tail_q]   <= new_we;
                addr_q[tail_q] <= wb_i_rd_addr;
                data_q[tail_q] <= new_data;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q    <= ~head_q;
                retired_q <= retired_q + CWIDTH'(1);
            end
            count_q <= count_d;
            ce_q    <= pop;
            flush_q <= wb_i_flush;
        end
    end

    // Register-file port shows the head entry.
    assign wb_o_rf_we   = !empty && we_q[head_q];
    assign wb_o_rf_addr = empty ? '0 : addr_q[head_q];
    assign wb_o_rf_data = empty ? '0 : data_q[head_q];

    // Forwarding: youngest writing entry (tail-1), then the head when two
    // entries are buffered. With 1-bit pointers tail-1 is ~tail.
    assign young_idx = ~tail_q;

    always_comb begin
        wb_o_fwd_we   = 1'b0;
        wb_o_fwd_addr = '0;
        wb_o_fwd_data = '0;
        if (!empty && we_q[young_idx]) begin
            wb_o_fwd_we   = 1'b1;
            wb_o_fwd_addr = addr_q[young_idx];
            wb_o_fwd_data = data_q[young_idx];
        end else if (full && we_q[head_q]) begin
            wb_o_fwd_we   = 1'b1;
            wb_o_fwd_addr = addr_q[head_q];
            wb_o_fwd_data = data_q[head_q];
        end
    end

    assign wb_o_stall   = full;
    assign wb_o_flush   = flush_q;
    assign wb_o_ce      = ce_q;
    assign wb_o_retired = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD_WORD
`define LOAD_WORD  7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif
`ifndef RTYPE
`define RTYPE      7'b0110011
`endif
`ifndef ITYPE
`define ITYPE      7'b0010011
`endif

module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 32;

    logic                     clk;
    logic                     rst;
    logic                     ce_i, stall_i, flush_i, rd_we_i, rf_ready_i;
    logic [`OPCODE_WIDTH-1:0] opcode_i;
    logic [AW-1:0]            rd_addr_i;
    logic [DW-1:0]            rd_data_i, load_data_i;
    logic                     rf_we_o, fwd_we_o, stall_o, flush_o, ce_o;
    logic [AW-1:0]            rf_addr_o, fwd_addr_o;
    logic [DW-1:0]            rf_data_o, fwd_data_o;
    logic [CW-1:0]            retired_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected register-file writes for the back-pressure scenario.
    logic [AW+DW-1:0] exp_q[$];

    wb_stage #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
        .wb_clk         (clk),
        .wb_rst         (rst),
        .wb_i_ce        (ce_i),
        .wb_i_stall     (stall_i),
        .wb_i_flush     (flush_i),
        .wb_i_opcode    (opcode_i),
        .wb_i_rd_addr   (rd_addr_i),
        .wb_i_rd_data   (rd_data_i),
        .wb_i_rd_we     (rd_we_i),
        .wb_i_load_data (load_data_i),
        .wb_i_rf_ready  (rf_ready_i),
        .wb_o_rf_we     (rf_we_o),
        .wb_o_rf_addr   (rf_addr_o),
        .wb_o_rf_data   (rf_data_o),
        .wb_o_fwd_we    (fwd_we_o),
        .wb_o_fwd_addr  (fwd_addr_o),
        .wb_o_fwd_data  (fwd_data_o),
        .wb_o_stall     (stall_o),
        .wb_o_flush     (flush_o),
        .wb_o_ce        (ce_o),
        .wb_o_retired   (retired_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_i        = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        opcode_i    = '0;
        rd_addr_i   = '0;
        rd_data_i   = '0;
        rd_we_i     = 1'b0;
        load_data_i = '0;
    endtask

    task automatic present(input logic [`OPCODE_WIDTH-1:0] op, input logic [AW-1:0] rd,
                           input logic [DW-1:0] data, input logic we, input logic [DW-1:0] ld);
        ce_i        = 1'b1;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        opcode_i    = op;
        rd_addr_i   = rd;
        rd_data_i   = data;
        rd_we_i     = we;
        load_data_i = ld;
    endtask

    // Scenarios
    task automatic test_reset();
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_rf: got %b/%0d/%h, required 0/0/0", rf_we_o, rf_addr_o, rf_data_o);
        end
        n_cmp++;
        if ({fwd_we_o, stall_o, flush_o, ce_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got fwd=%b stall=%b flush=%b ce=%b, required all 0",
                     fwd_we_o, stall_o, flush_o, ce_o);
        end
        n_cmp++;
        if (retired_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_retired: got %0d, required 0", retired_o);
        end
    endtask

    task automatic test_back_to_back();
        rf_ready_i = 1'b1;
        present(`RTYPE, 5'd5, 32'h11, 1'b1, 32'h0);
        step();
        present(`ITYPE, 5'd6, 32'h22, 1'b1, 32'h0);
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o, fwd_we_o, fwd_addr_o, fwd_data_o, ce_o} !==
            {1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first: got rf=%b/%0d/%h fwd=%b/%0d/%h ce=%b, required rf=1/5/11 fwd=1/5/11 ce=0",
                     rf_we_o, rf_addr_o, rf_data_o, fwd_we_o, fwd_addr_o, fwd_data_o, ce_o);
        end
        step();
        idle();
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o, ce_o, retired_o} !== {1'b1, 5'd6, 32'h22, 1'b1, 32'd1}) begin
            n_fail++;
            $display("FAIL b2b_second: got rf=%b/%0d/%h ce=%b ret=%0d, required rf=1/6/22 ce=1 ret=1",
                     rf_we_o, rf_addr_o, rf_data_o, ce_o, retired_o);
        end
        step();
        n_cmp++;
        if ({rf_we_o, ce_o, retired_o} !== {1'b0, 1'b1, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_drain: got rf_we=%b ce=%b ret=%0d, required 0/1/2", rf_we_o, ce_o, retired_o);
        end
        step();
        n_cmp++;
        if ({ce_o, retired_o} !== {1'b0, 32'd2}) begin
            n_fail++;
            $display("FAIL b2b_quiet: got ce=%b ret=%0d, required 0/2", ce_o, retired_o);
        end
    endtask

    task automatic test_load();
        present(`LOAD_WORD, 5'd7, 32'h1234, 1'b0, 32'hDEADBEEF);
        step();
        idle();
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL load_write: got %b/%0d/%h, required 1/7/deadbeef", rf_we_o, rf_addr_o, rf_data_o);
        end
        step();
        n_cmp++;
        if ({ce_o, retired_o} !== {1'b1, 32'd3}) begin
            n_fail++;
            $display("FAIL load_retire: got ce=%b ret=%0d, required 1/3", ce_o, retired_o);
        end
    endtask

    task automatic test_x0_store();
        present(`LOAD_WORD, 5'd0, 32'h0, 1'b1, 32'hCAFE0000);
        step();
        idle();
        n_cmp++;
        if ({rf_we_o, fwd_we_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL x0_nowrite: got rf_we=%b fwd_we=%b, required 0/0", rf_we_o, fwd_we_o);
        end
        step();
        n_cmp++;
        if ({ce_o, retired_o} !== {1'b1, 32'd4}) begin
            n_fail++;
            $display("FAIL x0_retire: got ce=%b ret=%0d, required 1/4", ce_o, retired_o);
        end
        present(`STORE_WORD, 5'd9, 32'h55, 1'b1, 32'h66);
        step();
        idle();
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o, fwd_we_o} !== {1'b0, 5'd9, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL store_nowrite: got rf=%b/%0d/%h fwd=%b, required 0/9/0 fwd=0",
                     rf_we_o, rf_addr_o, rf_data_o, fwd_we_o);
        end
        step();
        n_cmp++;
        if ({ce_o, retired_o} !== {1'b1, 32'd5}) begin
            n_fail++;
            $display("FAIL store_retire: got ce=%b ret=%0d, required 1/5", ce_o, retired_o);
        end
    endtask

    task automatic test_back_pressure();
        logic [AW+DW-1:0] exp;
        rf_ready_i = 1'b0;
        exp_q.push_back({5'd1, 32'hA1});
        exp_q.push_back({5'd2, 32'hB2});
        exp_q.push_back({5'd3, 32'hC3});
        present(`RTYPE, 5'd1, 32'hA1, 1'b1, 32'h0);
        step();
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_one_entry_stall: got %b, required 0", stall_o);
        end
        present(`RTYPE, 5'd2, 32'hB2, 1'b1, 32'h0);
        step();
        // Third instruction is presented and held while stall is high.
        present(`RTYPE, 5'd3, 32'hC3, 1'b1, 32'h0);
        n_cmp++;
        if ({stall_o, fwd_we_o, fwd_addr_o, fwd_data_o} !== {1'b1, 1'b1, 5'd2, 32'hB2}) begin
            n_fail++;
            $display("FAIL bp_full: got stall=%b fwd=%b/%0d/%h, required stall=1 fwd=1/2/b2",
                     stall_o, fwd_we_o, fwd_addr_o, fwd_data_o);
        end
        step();
        n_cmp++;
        if ({stall_o, rf_we_o, rf_addr_o, rf_data_o, ce_o} !== {1'b1, 1'b1, 5'd1, 32'hA1, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold: got stall=%b rf=%b/%0d/%h ce=%b, required 1 rf=1/1/a1 ce=0",
                     stall_o, rf_we_o, rf_addr_o, rf_data_o, ce_o);
        end
        rf_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL bp_order_%0d: got %b/%0d/%h, required 1/%0d/%h",
                         k, rf_we_o, rf_addr_o, rf_data_o, exp[DW+AW-1:DW], exp[DW-1:0]);
            end
            step();
            if (k == 0) begin
                n_cmp++;
                if ({stall_o, ce_o, retired_o} !== {1'b0, 1'b1, 32'd6}) begin
                    n_fail++;
                    $display("FAIL bp_release: got stall=%b ce=%b ret=%0d, required 0/1/6",
                             stall_o, ce_o, retired_o);
                end
            end
            if (k == 1) idle();
        end
        n_cmp++;
        if ({rf_we_o, ce_o, retired_o} !== {1'b0, 1'b1, 32'd8}) begin
            n_fail++;
            $display("FAIL bp_done: got rf_we=%b ce=%b ret=%0d, required 0/1/8", rf_we_o, ce_o, retired_o);
        end
        step();
    endtask

    task automatic test_flush_stall();
        rf_ready_i = 1'b0;
        present(`RTYPE, 5'd4, 32'hD4, 1'b1, 32'h0);
        step();
        present(`RTYPE, 5'd10, 32'hEE, 1'b1, 32'h0);
        flush_i = 1'b1;
        step();
        n_cmp++;
        if ({flush_o, rf_we_o, rf_addr_o, fwd_addr_o, fwd_data_o, stall_o} !==
            {1'b1, 1'b1, 5'd4, 5'd4, 32'hD4, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_drop: got flush=%b rf=%b/%0d fwd=%0d/%h stall=%b, required 1 rf=1/4 fwd=4/d4 stall=0",
                     flush_o, rf_we_o, rf_addr_o, fwd_addr_o, fwd_data_o, stall_o);
        end
        flush_i    = 1'b0;
        stall_i    = 1'b1;
        rf_ready_i = 1'b1;
        step();
        n_cmp++;
        if ({flush_o, ce_o, rf_we_o, retired_o} !== {1'b0, 1'b1, 1'b0, 32'd9}) begin
            n_fail++;
            $display("FAIL stall_block: got flush=%b ce=%b rf_we=%b ret=%0d, required 0/1/0/9",
                     flush_o, ce_o, rf_we_o, retired_o);
        end
        idle();
        step();
        n_cmp++;
        if ({ce_o, rf_we_o, retired_o} !== {1'b0, 1'b0, 32'd9}) begin
            n_fail++;
            $display("FAIL flush_quiet: got ce=%b rf_we=%b ret=%0d, required 0/0/9", ce_o, rf_we_o, retired_o);
        end
    endtask

    task automatic test_reset_mid();
        rf_ready_i = 1'b0;
        present(`RTYPE, 5'd8, 32'h88, 1'b1, 32'h0);
        step();
        present(`RTYPE, 5'd9, 32'h99, 1'b1, 32'h0);
        step();
        idle();
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_full: got stall=%b, required 1", stall_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o, fwd_we_o, fwd_addr_o, fwd_data_o, stall_o, ce_o, flush_o, retired_o} !==
            {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got rf=%b/%0d/%h fwd=%b/%0d/%h stall=%b ce=%b ret=%0d, required all 0",
                     rf_we_o, rf_addr_o, rf_data_o, fwd_we_o, fwd_addr_o, fwd_data_o, stall_o, ce_o, retired_o);
        end
        @(negedge clk);
        rst = 1'b0;
        rf_ready_i = 1'b1;
        present(`RTYPE, 5'd10, 32'hAA, 1'b1, 32'h0);
        step();
        idle();
        n_cmp++;
        if ({rf_we_o, rf_addr_o, rf_data_o} !== {1'b1, 5'd10, 32'hAA}) begin
            n_fail++;
            $display("FAIL rst_fresh_write: got %b/%0d/%h, required 1/10/aa", rf_we_o, rf_addr_o, rf_data_o);
        end
        step();
        n_cmp++;
        if ({ce_o, retired_o, rf_we_o} !== {1'b1, 32'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_fresh_retire: got ce=%b ret=%0d rf_we=%b, required 1/1/0", ce_o, retired_o, rf_we_o);
        end
    endtask

    initial begin
        rst        = 1'b1;
        rf_ready_i = 1'b0;
        idle();
        #12;
        test_reset();
        rst = 1'b0;
        step();
        test_back_to_back();
        test_load();
        test_x0_store();
        test_back_pressure();
        test_flush_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage core: consumes the memory stage's registered outputs and commits results to the register-file write port. A two-entry buffer absorbs cycles when the register-file port is not ready, and back-pressures the memory stage when full. Also provides the forwarding value to the decode/execute hazard logic, a retire pulse, and an instructions-retired counter.

## Interface
- DWIDTH, 32, data width
- AWIDTH, 5, register address width
- CWIDTH, 32, retired-counter width
- wb_clk  in  1  clock, rising edge
- wb_rst  in  1  reset; asynchronous, active-high
- wb_i_ce  in  1  memory stage presents a valid instruction this cycle
- wb_i_stall  in  1  memory stage stall; blocks capture of the input
- wb_i_flush  in  1  flush; the input this cycle is discarded
- wb_i_opcode  in  `OPCODE_WIDTH  opcode of the presented instruction
- wb_i_rd_addr  in  AWIDTH  destination register
- wb_i_rd_data  in  DWIDTH  ALU / link / immediate result
- wb_i_rd_we  in  1  result-write request for non-load opcodes
- wb_i_load_data  in  DWIDTH  load data
- wb_i_rf_ready  in  1  register-file write port accepts a write this cycle
- wb_o_rf_we  out  1  register-file write enable
- wb_o_rf_addr  out  AWIDTH  register-file write address
- wb_o_rf_data  out  DWIDTH  register-file write data
- wb_o_fwd_we  out  1  forwarding value valid
- wb_o_fwd_addr  out  AWIDTH  forwarding register address
- wb_o_fwd_data  out  DWIDTH  forwarding value
- wb_o_stall  out  1  buffer full; memory stage must hold
- wb_o_flush  out  1  registered copy of wb_i_flush
- wb_o_ce  out  1  retire pulse, registered
- wb_o_retired  out  CWIDTH  retired-instruction count

## Operation
- **Entry format:** we, addr, data. Entries live in a 2-deep FIFO with a head pointer, tail pointer and 2-bit count (0..2).
- **Push condition:** wb_i_ce && !wb_i_stall && !wb_i_flush && count<2.
- **Entry content by opcode:**
  - `LOAD_WORD: data=wb_i_load_data, we=1.
  - `RTYPE/`ITYPE/`JAL/`JALR/`LUI/`AUIPC: data=wb_i_rd_data, we=wb_i_rd_we.
  - All other opcodes (store, branch, unknown): we=0, data=0. These still retire.
  - we is forced 0 when wb_i_rd_addr==0 (x0 never written).
- **Stall:** wb_o_stall = (count==2). It depends only on registered state.
- **Register-file port:** wb_o_rf_we = (count!=0) && head.we. wb_o_rf_addr and wb_o_rf_data show head.addr and head.data when count!=0, else 0.
- **Pop condition:** count!=0 && (!head.we || wb_i_rf_ready). Non-writing entries pop without waiting for ready.
- **Simultaneous push and pop:**
  - count=1: count stays 1.
  - count=2: no push is possible, so a pop alone takes count to 1.
  - count=0: push only; pop is impossible.
- **Forwarding:** source is the youngest buffered entry with we=1 (tail-1 first, then head). If no such entry exists, fwd_we=0 and fwd_addr/data=0.
- **Flush:** affects only the input. Buffered entries are older and always commit. wb_o_flush <= wb_i_flush every cycle.
- **Retire:** wb_o_ce <= pop. wb_o_retired increments by 1 on each pop and wraps modulo 2^CWIDTH.
- **Reset (wb_rst=1, asynchronous):**
  - count, pointers, entries, wb_o_ce, wb_o_flush and wb_o_retired go to 0.
  - Therefore rf_we=0, fwd_we=0 and stall=0.
  - An entry buffered when reset asserts is lost and never written.

## Timing
- Input captured at edge E. The entry appears on wb_o_rf_* in the cycle after E.
- With rf_ready=1 the entry commits at edge E+1. wb_o_ce is high and wb_o_retired updated in the cycle after E+1.
- Best-case throughput: one instruction per cycle with count oscillating 0→1→0, or held at 1 under back-to-back traffic.
- rf_ready low for N cycles with continuous input: count reaches 2 after 2 pushes, and stall asserts the cycle after the second push.
- Stall deasserts the cycle after the first pop.
- Forwarding outputs change in the same cycles as count and the entries (registered-state only).

## Test plan
- **Back-to-back commit:** rf_ready=1; push RTYPE rd=5 data=0x11, then ITYPE rd=6 data=0x22 on consecutive cycles → rf writes (5,0x11) then (6,0x22) on successive cycles; wb_o_ce high 2 cycles; retired=2.
- **Load path:** push LOAD_WORD rd=7, load_data=0xDEADBEEF, rd_data=0x1234 → write (7,0xDEADBEEF).
- **x0 and store:** push LOAD_WORD rd=0 → no write, retired+1. Push STORE_WORD → no write, retired+1.
- **Back-pressure:** rf_ready=0; push 3 writes → first two buffered, stall=1, third held by the memory stage. fwd shows the second entry. Raise rf_ready → writes in order, stall drops one cycle after the first pop, third then accepted.
- **Flush and stall inputs:** wb_i_ce=1 with wb_i_flush=1, or with wb_i_stall=1 → nothing pushed, no retire. wb_o_flush=1 one cycle after the flush cycle. A buffered entry still commits.
- **Reset mid-operation:** count=2 with rf_ready=0; assert wb_rst asynchronously → all outputs 0 immediately; retired=0. After release, a fresh push commits normally.
